// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core sharing one word-addressed memory port for fetch and data.
// Halts permanently on any opcode or funct outside the supported set.
module mc_cpu #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        DBG_SEL  = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [2:0]        state,
  output logic [31:0]       retired,
  output logic [31:0]       dbg_bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [31:0]         ir_q, a_q, b_q, alu_q, mdr_q, wb_q, retired_q;
  logic [31:0]         rf_q [32];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_valid;

  always_comb begin
    is_rtype = (opcode == OpRtype) && (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt});
    is_addi  = (opcode == OpAddi);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_beq   = (opcode == OpBeq);
    is_j     = (opcode == OpJ);
    is_valid = is_rtype | is_addi | is_lw | is_sw | is_beq | is_j;
  end

  // Next-PC candidates, all modulo 2^ADDR_W
  logic [ADDR_W-1:0] pc_inc, pc_br, pc_jump;
  logic [31:0]       pc_inc_ext, jump_full;

  always_comb begin
    pc_inc     = pc_q + 1'b1;
    pc_br      = pc_inc + imm_ext[ADDR_W-1:0];
    pc_inc_ext = 32'(pc_inc);
    jump_full  = {pc_inc_ext[31:26], ir_q[25:0]};
    pc_jump    = jump_full[ADDR_W-1:0];
  end

  logic [31:0] alu_res;

  always_comb begin
    alu_res = a_q + imm_ext;
    if (is_rtype) begin
      unique case (funct)
        FnSub:   alu_res = a_q - b_q;
        FnAnd:   alu_res = a_q & b_q;
        FnOr:    alu_res = a_q | b_q;
        FnSlt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  logic [4:0]  wb_dst;
  logic [31:0] wb_val;

  assign wb_dst = is_rtype ? rd : rt;
  assign wb_val = is_lw ? mdr_q : alu_q;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (!is_valid)  state_d = StHalt;
        else if (is_j)  state_d = StFetch;
        else            state_d = StExec;
      end
      StExec: begin
        if (is_beq)              state_d = StFetch;
        else if (is_lw || is_sw) state_d = StMem;
        else                     state_d = StWb;
      end
      StMem:    if (mem_ready) state_d = is_sw ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StHalt;
    endcase
  end

  logic retire;

  // FSM: outputs; reset masks the request so it drops the moment reset rises
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    retire   = 1'b0;
    unique case (state_q)
      StFetch:  mem_req = 1'b1;
      StDecode: retire  = is_j;
      StExec:   retire  = is_beq;
      StMem: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = alu_q[ADDR_W-1:0];
        retire   = is_sw && mem_ready;
      end
      StWb:     retire  = 1'b1;
      default:  ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  assign mem_wdata = b_q;
  assign halted    = (state_q == StHalt);
  assign state     = state_q;
  assign retired   = retired_q;

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      wb_q  <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StFetch: if (mem_ready) ir_q <= mem_rdata;
        StDecode: begin
          a_q <= rf_q[rs];
          b_q <= rf_q[rt];
          if (is_j) pc_q <= pc_jump;
        end
        StExec: begin
          alu_q <= alu_res;
          if (is_beq) pc_q <= (a_q == b_q) ? pc_br : pc_inc;
        end
        StMem: begin
          if (mem_ready) begin
            if (is_sw) pc_q  <= pc_inc;
            else       mdr_q <= mem_rdata;
          end
        end
        StWb: begin
          if (wb_dst != 5'd0) rf_q[wb_dst] <= wb_val;
          wb_q <= wb_val;
          pc_q <= pc_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    if (DBG_SEL == 1)      dbg_bus = 32'(pc_q);
    else if (DBG_SEL == 2) dbg_bus = wb_q;
    else                   dbg_bus = ir_q;
  end

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: small programs in a behavioural memory with programmable
// wait states; results are read back from stored words, retire timing and fetch addresses.
module tb_mc_cpu;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, mem_ready, halted;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, retired, dbg_bus;
  logic [2:0]    state;

  always #5 clk = ~clk;

  mc_cpu #(
    .ADDR_W  (AW),
    .RESET_PC(8'h10),
    .DBG_SEL (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .halted   (halted),
    .state    (state),
    .retired  (retired),
    .dbg_bus  (dbg_bus)
  );

  // Behavioural memory; wait states apply separately to fetches and data accesses
  logic [31:0] mem [256];
  int unsigned lat_fetch = 0, lat_data = 0, wcnt = 0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_req && (wcnt >= ((state == 3'd3) ? lat_data : lat_fetch));

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ready) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
    if (!reset && mem_req && mem_we && mem_ready) begin
      mem[mem_addr] = mem_wdata;
      last_waddr    = mem_addr;
      last_wdata    = mem_wdata;
    end
  end

  // Request stability monitor across wait cycles
  int unsigned   hold_seen = 0, hold_err = 0;
  logic          prev_wait = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [31:0]   p_wdata = '0;

  always @(negedge clk) begin
    if (prev_wait && !reset) begin
      hold_seen++;
      if (!mem_req || mem_addr !== p_addr || mem_we !== p_we || (p_we && mem_wdata !== p_wdata))
        hold_err++;
    end
    prev_wait = mem_req && !mem_ready && !reset;
    p_addr    = mem_addr;
    p_we      = mem_we;
    p_wdata   = mem_wdata;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic hold_reset();
    @(negedge clk);
    reset     = 1'b1;
    lat_fetch = 0;
    lat_data  = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ret(input logic [31:0] tgt, input int budget, output int cyc);
    cyc = 0;
    while (retired !== tgt && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("retire_wait", retired, tgt);
  endtask

  initial begin
    int c;
    int req_hi;

    // Reset state, first fetch, ALU program
    hold_reset();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[8'h11] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[8'h12] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[8'h13] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    mem[8'h14] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
    mem[8'h15] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0041);
    mem[8'h16] = enc_r(5'd2, 5'd1, 5'd7, 6'h22);
    mem[8'h17] = enc_r(5'd1, 5'd2, 5'd8, 6'h24);
    mem[8'h18] = enc_r(5'd1, 5'd2, 5'd9, 6'h25);
    mem[8'h19] = enc_r(5'd1, 5'd2, 5'd10, 6'h2A);
    mem[8'h1A] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0042);
    mem[8'h1B] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0043);
    mem[8'h1C] = enc_i(6'h2B, 5'd0, 5'd9, 16'h0044);
    mem[8'h1D] = enc_i(6'h2B, 5'd0, 5'd10, 16'h0045);
    mem[8'h1E] = enc_j(26'h1E);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_retired", retired, 0);
    check("rst_dbg", dbg_bus, 0);
    release_reset();
    #1;
    check("first_req", 32'(mem_req), 1);
    check("first_we", 32'(mem_we), 0);
    check("first_addr", 32'(mem_addr), 32'h10);
    repeat (15) @(negedge clk);
    check("ret_at_15", retired, 3);
    @(negedge clk);
    check("ret_at_16", retired, 4);
    check("slt_wb", dbg_bus, 1);
    repeat (100) @(negedge clk);
    check("r3_add", mem[8'h40], 2);
    check("r4_slt", mem[8'h41], 1);
    check("r7_sub", mem[8'h42], 32'hFFFF_FFF8);
    check("r8_and", mem[8'h43], 5);
    check("r9_or", mem[8'h44], 32'hFFFF_FFFD);
    check("r10_slt_signed", mem[8'h45], 0);

    // Store/load with three data wait states
    hold_reset();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[8'h11] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    mem[8'h12] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    mem[8'h13] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0046);
    mem[8'h14] = enc_j(26'h14);
    lat_data = 3;
    release_reset();
    wait_ret(1, 50, c);
    wait_ret(2, 50, c);
    check("sw_cycles", c, 7);
    check("sw_addr", 32'(last_waddr), 8);
    check("sw_data", last_wdata, 5);
    wait_ret(3, 50, c);
    check("lw_cycles", c, 8);
    check("lw_wb", dbg_bus, 5);
    wait_ret(4, 50, c);
    check("r5_stored", mem[8'h46], 5);
    check("hold_err", hold_err, 0);
    check("hold_seen", 32'(hold_seen >= 6), 1);

    // beq self-loop reached through j
    hold_reset();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[8'h11] = enc_j(26'h4);
    mem[8'h04] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    release_reset();
    wait_ret(1, 50, c);
    wait_ret(2, 50, c);
    check("j_cycles", c, 2);
    check("j_target", 32'(mem_addr), 4);
    wait_ret(3, 50, c);
    check("beq_cycles", c, 3);
    check("beq_loop", 32'(mem_addr), 4);
    wait_ret(4, 50, c);
    check("beq_loop2", 32'(mem_addr), 4);

    // PC wrap: j truncation, increment past 0xFF, not-taken and wrapping branches
    hold_reset();
    mem[8'h10] = enc_j(26'h3FF_FFFF);
    mem[8'hFF] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[8'h00] = enc_i(6'h04, 5'd0, 5'd2, 16'd3);
    mem[8'h01] = enc_i(6'h04, 5'd0, 5'd0, 16'h00FD);
    release_reset();
    wait_ret(1, 50, c);
    check("j_trunc", 32'(mem_addr), 32'hFF);
    wait_ret(2, 50, c);
    check("pc_wrap", 32'(mem_addr), 0);
    wait_ret(3, 50, c);
    check("bnt_cycles", c, 3);
    check("beq_not_taken", 32'(mem_addr), 1);
    wait_ret(4, 50, c);
    check("beq_wrap", 32'(mem_addr), 32'hFF);

    // Unsupported opcode halts in decode
    hold_reset();
    mem[8'h10] = enc_j(26'h7);
    mem[8'h07] = 32'hFC00_0000;
    release_reset();
    wait_ret(1, 50, c);
    c = 0;
    while (state !== 3'd5 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("halt_cycles", c, 2);
    check("halted", 32'(halted), 1);
    req_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) req_hi++;
    end
    check("halt_no_req", req_hi, 0);
    check("halt_state", 32'(state), 5);
    check("halt_retired", retired, 1);

    // r0 hardwired to zero, then reset during a waiting load
    hold_reset();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd6, 16'd3);
    mem[8'h11] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    mem[8'h12] = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
    mem[8'h13] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0047);
    mem[8'h14] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    mem[8'h15] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0048);
    mem[8'h16] = enc_j(26'h16);
    mem[8'h47] = 32'hDEAD;
    mem[8'h48] = 32'hBEEF;
    mem[8'h08] = 32'h1234;
    release_reset();
    wait_ret(4, 80, c);
    check("r6_zero", mem[8'h47], 0);
    check("r0_add_wb", dbg_bus, 0);
    lat_data = 3;
    c = 0;
    while (state !== 3'd3 && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("lw_pending", {30'b0, mem_req, mem_ready}, 32'b10);
    reset = 1'b1;
    #1;
    check("abort_state", 32'(state), 0);
    check("abort_req", 32'(mem_req), 0);
    check("abort_retired", retired, 0);
    check("abort_wb", dbg_bus, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("refetch_req", 32'(mem_req), 1);
    check("refetch_addr", 32'(mem_addr), 32'h10);
    check("no_store", mem[8'h48], 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 The block SHALL be parametrised as: ADDR_W, 32, word-address width; RESET_PC, 0, PC value loaded at reset; DBG_SEL, 0, dbg_bus source (0 instr, 1 PC zero-extended, 2 last writeback value).
REQ-002 The block SHALL provide these ports, one per line below.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_req  out  1  memory transaction request.
REQ-006 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-007 mem_addr  out  ADDR_W  word address; valid while mem_req.
REQ-008 mem_wdata  out  32  store data; valid while mem_req & mem_we.
REQ-009 mem_rdata  in  32  read data, sampled in the completing cycle.
REQ-010 mem_ready  in  1  transaction completes in any cycle with mem_req & mem_ready high.
REQ-011 halted  out  1  core stopped on unsupported opcode.
REQ-012 state  out  3  FSM state code: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5.
REQ-013 retired  out  32  count of completed instructions.
REQ-014 dbg_bus  out  32  debug view selected by DBG_SEL.

Function
REQ-015 Single shared instruction/data memory port; word addressing; PC+1 means the next instruction.
REQ-016 Once mem_req rises, mem_we, mem_addr and mem_wdata SHALL hold until the completing cycle; mem_req drops the cycle after completion unless a new transaction starts.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; waits any number of cycles; on completion latches mem_rdata into IR, goes to DECODE.
REQ-018 DECODE: reads rs=IR[25:21], rt=IR[20:16] into A/B latches; j: PC <= {PC+1 upper bits above 26, IR[25:0]} truncated to ADDR_W, retire, go FETCH; unsupported opcode/funct -> HALT; otherwise EXEC.
REQ-019 Supported set: R-type (op 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-020 EXEC: ALU result latched; add/sub wrap mod 2^32, no overflow trap; addi/lw/sw use sign-extended IR[15:0]; beq: if A==B PC <= PC+1+sext(imm) else PC+1 (mod 2^ADDR_W), retire, go FETCH; lw/sw -> MEM; R-type/addi -> WB.
REQ-021 MEM: mem_addr = ALU result[ADDR_W-1:0]; sw: mem_we=1, mem_wdata=rt value, on completion PC+1, retire, FETCH; lw: on completion latch mem_rdata, go WB.
REQ-022 WB: write result to rd=IR[15:11] (R-type) or rt (addi, lw); PC <= PC+1; retire; go FETCH.
REQ-023 Register file: 32 x 32 bits, 2 read ports, 1 write port; writes to r0 ignored, r0 always reads 0.
REQ-024 Cycle counts with mem_ready tied high: j 2, beq 3, R-type/addi/sw 4, lw 5; each wait cycle adds 1.
REQ-025 retired increments by 1 exactly in the retiring cycle and wraps 0xFFFFFFFF -> 0.
REQ-026 HALT: terminal until reset; mem_req=0, halted=1, no register, PC or retired change; PC holds the faulting instruction's address.
REQ-027 PC SHALL wrap modulo 2^ADDR_W on increment and branch.

Reset
REQ-028 reset high SHALL immediately force: state=FETCH, PC=RESET_PC, all registers 0, IR 0, retired 0, halted 0, mem_req 0, mem_we 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no register or PC update; the first fetch after deassertion SHALL be from RESET_PC.

Verification
REQ-030 Reset RESET_PC=0x10, ready high: first mem_req after deassert has mem_addr=0x10, mem_we=0; retired=0.
REQ-031 Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1, retired=4 after 16 cycles.
REQ-032 sw r1,8(r0) then lw r5,8(r0) with mem_ready low 3 cycles per access -> write at addr 8 data 5 held stable while waiting; r5=5; sw 7 cycles, lw 8 cycles.
REQ-033 beq r1,r1,-1 at PC 4 -> next fetch addr 4 (loop); j 0x3FFFFFF with ADDR_W=8 -> PC=0xFF; PC 0xFF +1 -> 0x00.
REQ-034 Opcode 0x3F at PC 7 -> HALT reached in DECODE, halted=1, state=5, mem_req stays 0 for 20 cycles, retired unchanged.
REQ-035 addi r0,r0,9 then add r6,r0,r0 -> r6=0; reset asserted during a waiting lw -> no register change, refetch from RESET_PC.
